// File: rtl/fir2d_mac.sv
// rtl/fir2d_mac.sv - pipelined 5x5 MAC core of the 2D FIR with frame-deferred coefficient banks
module fir2d_mac #(
   parameter int SHIFT = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [399:0] coeff_i,
   input  logic         coeff_en_i,
   input  logic [199:0] pix_i,
   input  logic         de_i,
   input  logic         hs_i,
   input  logic         vs_i,
   output logic [7:0]   dout_o,
   output logic         de_o,
   output logic         hs_o,
   output logic         vs_o,
   output logic         coeff_pending_o
);

   // Identity kernel: only the centre tap (row 2, col 2 -> slot 12) is 1.0
   localparam logic [15:0]  C_ONE = 16'(1) << SHIFT;
   localparam logic [399:0] IDENT = {192'd0, C_ONE, 192'd0};
   // Half an LSB of the output; zero when there are no fractional bits
   localparam logic signed [31:0] RND = (32'sd1 << SHIFT) >>> 1;

   // Coefficient banks
   logic [399:0] act_q, act_d;
   logic [399:0] pend_q, pend_d;
   logic         pend_flag_q, pend_flag_d;
   logic         vs_prev_q, vs_prev_d;
   logic         vs_rise;

   // Datapath stages
   logic [199:0]       pix1_q, pix1_d;
   logic signed [24:0] prod_q [25];
   logic signed [24:0] prod_d [25];
   logic signed [27:0] row_q [5];
   logic signed [27:0] row_d [5];
   logic signed [30:0] sum_q, sum_d;
   logic [7:0]         dout_q, dout_d;
   logic signed [31:0] rnd_sum;
   logic signed [31:0] shifted;

   // Sync delay line, {de, hs, vs} per stage
   logic [2:0] sync_q [5];
   logic [2:0] sync_d [5];

   // Bank update: a frame-start rise promotes pending (or a coincident strobe) into active
   always_comb begin
      vs_rise     = vs_i & ~vs_prev_q;
      vs_prev_d   = vs_i;
      act_d       = act_q;
      pend_d      = pend_q;
      pend_flag_d = pend_flag_q;
      if (vs_rise && coeff_en_i) begin
         act_d       = coeff_i;
         pend_flag_d = 1'b0;
      end else if (vs_rise && pend_flag_q) begin
         act_d       = pend_q;
         pend_flag_d = 1'b0;
      end else if (coeff_en_i) begin
         pend_d      = coeff_i;
         pend_flag_d = 1'b1;
      end
   end

   // Multiply, row-sum, total, then round/shift/saturate; runs every cycle regardless of de
   always_comb begin
      pix1_d = pix_i;
      for (int i = 0; i < 25; i++) begin
         prod_d[i] = 25'($signed({1'b0, pix1_q[8*i +: 8]})) * 25'($signed(act_q[16*i +: 16]));
      end
      for (int r = 0; r < 5; r++) begin
         row_d[r] = 28'(prod_q[5*r])   + 28'(prod_q[5*r+1]) + 28'(prod_q[5*r+2])
                  + 28'(prod_q[5*r+3]) + 28'(prod_q[5*r+4]);
      end
      sum_d   = 31'(row_q[0]) + 31'(row_q[1]) + 31'(row_q[2]) + 31'(row_q[3]) + 31'(row_q[4]);
      rnd_sum = 32'(sum_q) + RND;
      shifted = rnd_sum >>> SHIFT;
      if (shifted < 32'sd0) begin
         dout_d = 8'd0;
      end else if (shifted > 32'sd255) begin
         dout_d = 8'hFF;
      end else begin
         dout_d = shifted[7:0];
      end
   end

   // Syncs follow the pixel through the same number of registers
   always_comb begin
      sync_d[0] = {de_i, hs_i, vs_i};
      for (int k = 1; k < 5; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   // State registers; reset restores the identity kernel and flushes the pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         act_q       <= IDENT;
         pend_q      <= '0;
         pend_flag_q <= 1'b0;
         vs_prev_q   <= 1'b0;
         pix1_q      <= '0;
         for (int i = 0; i < 25; i++) prod_q[i] <= '0;
         for (int r = 0; r < 5; r++) row_q[r] <= '0;
         sum_q       <= '0;
         dout_q      <= '0;
         for (int k = 0; k < 5; k++) sync_q[k] <= '0;
      end else begin
         act_q       <= act_d;
         pend_q      <= pend_d;
         pend_flag_q <= pend_flag_d;
         vs_prev_q   <= vs_prev_d;
         pix1_q      <= pix1_d;
         for (int i = 0; i < 25; i++) prod_q[i] <= prod_d[i];
         for (int r = 0; r < 5; r++) row_q[r] <= row_d[r];
         sum_q       <= sum_d;
         dout_q      <= dout_d;
         for (int k = 0; k < 5; k++) sync_q[k] <= sync_d[k];
      end
   end

   assign dout_o          = dout_q;
   assign de_o            = sync_q[4][2];
   assign hs_o            = sync_q[4][1];
   assign vs_o            = sync_q[4][0];
   assign coeff_pending_o = pend_flag_q;

endmodule

// File: tb/tb_fir2d_mac.sv
// tb/tb_fir2d_mac.sv - directed vector and sequence bench for fir2d_mac
module tb_fir2d_mac;

   localparam int SHIFT = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [399:0] coeff_i;
   logic         coeff_en_i;
   logic [199:0] pix_i;
   logic         de_i, hs_i, vs_i;
   logic [7:0]   dout_o;
   logic         de_o, hs_o, vs_o;
   logic         coeff_pending_o;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [399:0] coeff;
      logic [199:0] pix;
      logic [7:0]   exp;
   } vec_t;

   vec_t vecs [12];

   always #5 clk = ~clk;

   fir2d_mac #(.SHIFT(SHIFT)) dut (
      .clk            (clk),
      .rst            (rst),
      .coeff_i        (coeff_i),
      .coeff_en_i     (coeff_en_i),
      .pix_i          (pix_i),
      .de_i           (de_i),
      .hs_i           (hs_i),
      .vs_i           (vs_i),
      .dout_o         (dout_o),
      .de_o           (de_o),
      .hs_o           (hs_o),
      .vs_o           (vs_o),
      .coeff_pending_o(coeff_pending_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   function automatic logic [399:0] one_c(input int idx, input logic [15:0] v);
      logic [399:0] t;
      t = '0;
      t[16*idx +: 16] = v;
      return t;
   endfunction

   function automatic logic [399:0] all_c(input logic [15:0] v);
      logic [399:0] t;
      for (int i = 0; i < 25; i++) t[16*i +: 16] = v;
      return t;
   endfunction

   function automatic logic [199:0] pix_ctr(input logic [7:0] base, input logic [7:0] ctr);
      logic [199:0] t;
      for (int i = 0; i < 25; i++) t[8*i +: 8] = base;
      t[8*12 +: 8] = ctr;
      return t;
   endfunction

   // Coefficient strobe coincident with a vs rise: direct load into the active bank
   task automatic load_direct(input logic [399:0] c);
      coeff_i    = c;
      coeff_en_i = 1'b1;
      vs_i       = 1'b1;
      step();
      coeff_en_i = 1'b0;
      vs_i       = 1'b0;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [399:0] ct;
      logic [199:0] pt;

      // Vector table, SHIFT = 4
      vecs[0]  = '{all_c(16'd1), pix_ctr(8'd16, 8'd16), 8'd25};
      vecs[1]  = '{one_c(12, 16'h7FFF), pix_ctr(8'd255, 8'd255), 8'd255};
      vecs[2]  = '{one_c(12, 16'hFFF0), pix_ctr(8'd50, 8'd50), 8'd0};
      for (int i = 0; i < 25; i++) ct[16*i +: 16] = (i < 8) ? 16'd2 : ((i < 24) ? 16'hFFFF : 16'd0);
      vecs[3]  = '{ct, pix_ctr(8'd10, 8'd10), 8'd0};
      vecs[4]  = '{one_c(12, 16'd16), pix_ctr(8'd7, 8'd100), 8'd100};
      vecs[5]  = '{one_c(12, 16'd1), pix_ctr(8'd8, 8'd8), 8'd1};
      vecs[6]  = '{one_c(12, 16'd1), pix_ctr(8'd7, 8'd7), 8'd0};
      vecs[7]  = '{one_c(12, 16'hFFFF), pix_ctr(8'd9, 8'd9), 8'd0};
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 5; c++) begin
            ct[16*(5*r+c) +: 16] = 16'(c);
            pt[8*(5*r+c) +: 8]   = 8'(10*r + c);
         end
      end
      vecs[8]  = '{ct, pt, 8'd72};
      for (int i = 0; i < 25; i++) begin
         ct[16*i +: 16] = (i < 5) ? 16'd3 : 16'd0;
         pt[8*i +: 8]   = (i < 5) ? 8'd20 : 8'd200;
      end
      vecs[9]  = '{ct, pt, 8'd19};
      vecs[10] = '{all_c(16'd1), pix_ctr(8'd255, 8'd255), 8'd255};
      vecs[11] = '{one_c(12, 16'd32) | one_c(0, 16'hFFF8), pix_ctr(8'd100, 8'd100), 8'd150};

      rst = 1'b1; coeff_i = '0; coeff_en_i = 1'b0; pix_i = '0;
      de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
      steps(2);
      check("reset_dout", dout_o, 0);
      check("reset_syncs", {de_o, hs_o, vs_o}, 0);
      check("reset_pending", coeff_pending_o, 0);
      rst = 1'b0;

      // Identity kernel after reset; zero until the fifth edge
      pix_i = pix_ctr(8'd7, 8'd100);
      for (int k = 1; k <= 5; k++) begin
         step();
         check($sformatf("identity_edge%0d", k), dout_o, (k < 5) ? 32'd0 : 32'd100);
      end

      // Table of kernels and windows
      for (int i = 0; i < 12; i++) begin
         pix_i = vecs[i].pix;
         load_direct(vecs[i].coeff);
         steps(3);
         check($sformatf("vec%0d", i), dout_o, vecs[i].exp);
      end

      // Frame-deferred update
      pix_i = pix_ctr(8'd16, 8'd16);
      load_direct(all_c(16'd1));
      steps(3);
      check("box_old", dout_o, 25);
      coeff_i = one_c(12, 16'd32); coeff_en_i = 1'b1;
      step();
      coeff_en_i = 1'b0;
      check("deferred_pending_set", coeff_pending_o, 1);
      steps(5);
      check("deferred_keep_old", dout_o, 25);
      check("deferred_pending_held", coeff_pending_o, 1);
      vs_i = 1'b1;
      step();
      check("rise_pending_clear", coeff_pending_o, 0);
      steps(3);
      check("pre_rise_old_set", dout_o, 25);
      check("pre_rise_vs_o", vs_o, 0);
      step();
      check("rise_new_set", dout_o, 32);
      check("rise_vs_o", vs_o, 1);

      // Two strobes before the rise: only the second applies
      vs_i = 1'b0;
      step();
      coeff_i = one_c(12, 16'd48); coeff_en_i = 1'b1;
      step();
      coeff_i = one_c(12, 16'd64);
      step();
      coeff_en_i = 1'b0;
      check("two_strobe_pending", coeff_pending_o, 1);
      vs_i = 1'b1;
      step();
      check("two_strobe_clear", coeff_pending_o, 0);
      steps(4);
      check("two_strobe_second", dout_o, 64);

      // Strobe coincident with rise
      vs_i = 1'b0;
      step();
      coeff_i = one_c(12, 16'd80); coeff_en_i = 1'b1; vs_i = 1'b1;
      step();
      coeff_en_i = 1'b0;
      check("simul_pending", coeff_pending_o, 0);
      steps(4);
      check("simul_direct", dout_o, 80);

      // Rise with nothing pending leaves active unchanged
      vs_i = 1'b0;
      step();
      vs_i = 1'b1;
      steps(5);
      check("rise_no_pending", dout_o, 80);
      check("rise_no_pending_flag", coeff_pending_o, 0);

      // Sync pulses aligned with a per-cycle marker pixel
      vs_i = 1'b0;
      step();
      load_direct(one_c(12, 16'd16));
      for (int k = 0; k < 12; k++) begin
         pix_i = pix_ctr(8'd7, 8'(10 + k));
         de_i  = (k == 2);
         hs_i  = (k == 3);
         vs_i  = (k == 4);
         step();
         if (k >= 4) begin
            check($sformatf("align_k%0d", k), {dout_o, de_o, hs_o, vs_o},
                  {21'd0, 8'(10 + k - 4), (k - 4 == 2), (k - 4 == 3), (k - 4 == 4)});
         end
      end
      de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;

      // Reset mid-stream with a set pending
      pix_i = pix_ctr(8'd50, 8'd50);
      load_direct(one_c(12, 16'd32));
      coeff_i = all_c(16'd1); coeff_en_i = 1'b1;
      step();
      coeff_en_i = 1'b0;
      de_i = 1'b1; hs_i = 1'b1;
      steps(4);
      check("pre_reset_dout", dout_o, 100);
      rst = 1'b1;
      step();
      check("midreset_dout", dout_o, 0);
      check("midreset_syncs", {de_o, hs_o, vs_o}, 0);
      check("midreset_pending", coeff_pending_o, 0);
      rst = 1'b0; de_i = 1'b0; hs_i = 1'b0;
      pix_i = pix_ctr(8'd7, 8'd100);
      steps(4);
      check("post_reset_flushed", dout_o, 0);
      step();
      check("post_reset_identity", dout_o, 100);
      vs_i = 1'b1;
      steps(5);
      check("post_reset_pending_dropped", dout_o, 100);
      vs_i = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
